// File: rtl/ca_row_renderer.sv
// rtl/ca_row_renderer.sv - elementary cellular automaton row renderer
//
// Displays one generation of a Wolfram elementary CA as a row of square
// cells. While a row of cells is on screen, the next generation is computed
// serially, one cell per clock, into a shadow register. The shadow is
// committed at the next cell-row boundary.
//
// Parameters:
//   CELLS       cells per generation (2..256)
//   CELL_SHIFT  log2 of the cell size in pixels (>= 1)
//   RULE        Wolfram rule number
//   FG_COLOR    colour of a live cell
//   BG_COLOR    colour of a dead cell and of blanking
//
// Ports:
//   clk          clock, all state on the rising edge
//   rst          asynchronous active-high reset
//   seed         initial generation (only with CA_SEED_INPUT_EN)
//   x, y         current pixel column / row
//   activevideo  high inside the visible area
//   color        registered pixel colour, one cycle after x/y/activevideo
//   busy         high while the next generation is being computed
//   overrun      sticky, a row boundary arrived before computation finished
//
// Build option: define CA_SEED_INPUT_EN to add the seed input port.
// Otherwise the seed is a single live cell at index CELLS/2.

module ca_row_renderer #(
  parameter int unsigned CELLS      = 80,
  parameter int unsigned CELL_SHIFT = 3,
  parameter logic [7:0]  RULE       = 8'd30,
  parameter logic [2:0]  FG_COLOR   = 3'b111,
  parameter logic [2:0]  BG_COLOR   = 3'b000
) (
  input  logic             clk,
  input  logic             rst,
`ifdef CA_SEED_INPUT_EN
  input  logic [CELLS-1:0] seed,
`endif
  input  logic [9:0]       x,
  input  logic [9:0]       y,
  input  logic             activevideo,
  output logic [2:0]       color,
  output logic             busy,
  output logic             overrun
);

  localparam int unsigned    IW         = $clog2(CELLS);
  localparam logic [IW-1:0]  LAST       = IW'(CELLS - 1);
  localparam logic [0:0]     ST_IDLE    = 1'b0;
  localparam logic [0:0]     ST_COMPUTE = 1'b1;

  logic [CELLS-1:0] seed_w;

`ifdef CA_SEED_INPUT_EN
  assign seed_w = seed;
`else
  localparam logic [CELLS-1:0] SEED_DEFAULT = CELLS'(1) << (CELLS / 2);
  assign seed_w = SEED_DEFAULT;
`endif

  logic [CELLS-1:0] gen_q, gen_d;
  logic [CELLS-1:0] shadow_q, shadow_d;
  logic [9:0]       y_q;
  logic [0:0]       state_q, state_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic             overrun_q, overrun_d;
  logic [2:0]       color_q, color_d;

  // Row events: any change of y is a new line; line 0 starts a frame, and a
  // line whose low CELL_SHIFT bits are zero starts a new row of cells.
  logic line_ev, frame_ev, bnd_ev;

  assign line_ev  = (y != y_q);
  assign frame_ev = line_ev && (y == 10'd0);
  assign bnd_ev   = line_ev && (y != 10'd0) && (y[CELL_SHIFT-1:0] == '0);

  // Neighbourhood of the cell being computed, wrapping at both ends.
  logic [IW-1:0] idx_left, idx_right;
  logic [2:0]    pattern;

  assign idx_left  = (idx_q == '0)  ? LAST : idx_q - IW'(1);
  assign idx_right = (idx_q == LAST) ? '0  : idx_q + IW'(1);
  assign pattern   = {gen_q[idx_left], gen_q[idx_q], gen_q[idx_right]};

  // Pixel lookup against the currently displayed generation.
  logic [9:0]    cell_col;
  logic [IW-1:0] cell_idx;
  logic          cell_in_range;

  assign cell_col      = x >> CELL_SHIFT;
  assign cell_in_range = (cell_col < 10'(CELLS));
  assign cell_idx      = cell_col[IW-1:0];

  always_comb begin
    color_d = BG_COLOR;
    if (activevideo && cell_in_range && gen_q[cell_idx]) begin
      color_d = FG_COLOR;
    end
  end

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    gen_d     = gen_q;
    shadow_d  = shadow_q;
    overrun_d = overrun_q;

    if (state_q == ST_COMPUTE) begin
      shadow_d[idx_q] = RULE[pattern];
      if (idx_q == LAST) begin
        state_d = ST_IDLE;
        idx_d   = '0;
      end else begin
        idx_d = idx_q + IW'(1);
      end
    end

    // Any event restarts the computation from cell 0; a boundary that finds
    // the previous computation unfinished keeps the displayed generation.
    if (frame_ev) begin
      gen_d   = seed_w;
      state_d = ST_COMPUTE;
      idx_d   = '0;
    end else if (bnd_ev) begin
      if (state_q == ST_IDLE) begin
        gen_d = shadow_q;
      end else begin
        overrun_d = 1'b1;
      end
      state_d = ST_COMPUTE;
      idx_d   = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      gen_q     <= seed_w;
      shadow_q  <= '0;
      y_q       <= 10'd0;
      state_q   <= ST_IDLE;
      idx_q     <= '0;
      overrun_q <= 1'b0;
      color_q   <= BG_COLOR;
    end else begin
      gen_q     <= gen_d;
      shadow_q  <= shadow_d;
      y_q       <= y;
      state_q   <= state_d;
      idx_q     <= idx_d;
      overrun_q <= overrun_d;
      color_q   <= color_d;
    end
  end

  assign color   = color_q;
  assign busy    = (state_q == ST_COMPUTE);
  assign overrun = overrun_q;

endmodule

// File: tb/tb_ca_row_renderer.sv
// tb/tb_ca_row_renderer.sv - self-checking bench for ca_row_renderer

module tb_ca_row_renderer;

  localparam int         CELLS = 80;
  localparam int         CSIZE = 8;
  localparam logic [7:0] RULE  = 8'd30;

  logic       clk = 1'b0;
  logic       rst;
  logic [9:0] x;
  logic [9:0] y;
  logic       activevideo;
  logic [2:0] color;
  logic       busy;
  logic       overrun;
`ifdef CA_SEED_INPUT_EN
  logic [CELLS-1:0] seed;
`endif

  ca_row_renderer dut (
    .clk         (clk),
    .rst         (rst),
`ifdef CA_SEED_INPUT_EN
    .seed        (seed),
`endif
    .x           (x),
    .y           (y),
    .activevideo (activevideo),
    .color       (color),
    .busy        (busy),
    .overrun     (overrun)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: displayed and pending generations as whole vectors,
  // computation modelled as a countdown that yields the full next generation.
  logic [CELLS-1:0] m_gen;
  logic [CELLS-1:0] m_shadow;
  int               m_last_y;
  int               m_busy_left;
  logic             m_overrun;
  logic [2:0]       m_color;

  function automatic logic [CELLS-1:0] cur_seed();
    logic [CELLS-1:0] s;
`ifdef CA_SEED_INPUT_EN
    s = seed;
`else
    s = '0;
    s[CELLS/2] = 1'b1;
`endif
    return s;
  endfunction

  function automatic logic [CELLS-1:0] ca_step(input logic [CELLS-1:0] g);
    logic [CELLS-1:0] s;
    logic [7:0]       rule_v;
    rule_v = RULE;
    for (int i = 0; i < CELLS; i++) begin
      int l;
      int r;
      int pat;
      l   = (i + CELLS - 1) % CELLS;
      r   = (i + 1) % CELLS;
      pat = 4 * int'(g[l]) + 2 * int'(g[i]) + int'(g[r]);
      s[i] = rule_v[pat];
    end
    return s;
  endfunction

  task automatic model_reset();
    m_gen       = cur_seed();
    m_shadow    = '0;
    m_last_y    = 0;
    m_busy_left = 0;
    m_overrun   = 1'b0;
    m_color     = 3'b000;
  endtask

  task automatic model_edge();
    int  c;
    int  yi;
    bit  was_busy;
    bit  line;
    c  = int'(x) / CSIZE;
    yi = int'(y);
    m_color = (activevideo && c < CELLS && m_gen[c]) ? 3'b111 : 3'b000;
    was_busy = (m_busy_left > 0);
    line     = (yi != m_last_y);
    if (line && yi == 0) begin
      m_gen       = cur_seed();
      m_busy_left = CELLS;
    end else if (line && (yi % CSIZE) == 0) begin
      if (was_busy) m_overrun = 1'b1;
      else          m_gen = m_shadow;
      m_busy_left = CELLS;
    end else if (was_busy) begin
      m_busy_left--;
      if (m_busy_left == 0) m_shadow = ca_step(m_gen);
    end
    m_last_y = yi;
  endtask

  task automatic tick();
    @(posedge clk);
    if (rst) model_reset();
    else     model_edge();
    @(negedge clk);
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst         = 1'b1;
    x           = 10'($urandom_range(0, 1023));
    y           = 10'($urandom_range(1, 1023));
    activevideo = 1'b1;
    ticks(2);
    checks++;
    if (color !== 3'b000) begin
      errors++; $display("FAIL reset_color: got %b expected 000", color);
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++; $display("FAIL reset_busy: got %b expected 0", busy);
    end
    checks++;
    if (overrun !== 1'b0) begin
      errors++; $display("FAIL reset_overrun: got %b expected 0", overrun);
    end
    y = 10'd0;
    rst = 1'b0;
    x = 10'd320;
    tick();
    checks++;
    if (color !== 3'b111) begin
      errors++; $display("FAIL reset_seed_cell: got %b expected 111", color);
    end
    x = 10'd319;
    tick();
    checks++;
    if (color !== 3'b000) begin
      errors++; $display("FAIL reset_left_of_seed: got %b expected 000", color);
    end
  endtask

  task automatic test_rule30_step();
    int xs[4];
    logic [2:0] exp_c[4];
    xs = '{312, 335, 311, 336};
    exp_c = '{3'b111, 3'b111, 3'b000, 3'b000};
    activevideo = 1'b1;
    y = 10'd1; tick();
    y = 10'd0; tick();
    ticks(90);
    y = 10'd7; tick();
    y = 10'd8; tick();
    for (int i = 0; i < 4; i++) begin
      x = 10'(xs[i]);
      tick();
      checks++;
      if (color !== exp_c[i] || color !== m_color) begin
        errors++;
        $display("FAIL rule30_x%0d: got %b expected %b (model %b)", xs[i], color, exp_c[i], m_color);
      end
    end
  endtask

  task automatic test_busy_timing();
    y = 10'd1;
    ticks(100);
    y = 10'd0;
    tick();
    for (int k = 0; k <= CELLS; k++) begin
      checks++;
      if (busy !== (k < CELLS)) begin
        errors++;
        $display("FAIL busy_cycle_%0d: got %b expected %b", k + 1, busy, (k < CELLS));
      end
      tick();
    end
  endtask

  task automatic test_blanking();
    pulse_reset();
    y = 10'd0;
    activevideo = 1'b0;
    x = 10'd320;
    tick();
    checks++;
    if (color !== 3'b000) begin
      errors++; $display("FAIL blank_live_cell: got %b expected 000", color);
    end
    activevideo = 1'b1;
    for (int i = 0; i < 3; i++) begin
      x = 10'($urandom_range(640, 1023));
      tick();
      checks++;
      if (color !== 3'b000) begin
        errors++; $display("FAIL out_of_range_x%0d: got %b expected 000", x, color);
      end
    end
  endtask

  task automatic test_overrun();
    activevideo = 1'b1;
    y = 10'd1; tick();
    y = 10'd0; tick();
    ticks(5);
    y = 10'd8; tick();
    checks++;
    if (overrun !== 1'b1) begin
      errors++; $display("FAIL overrun_set: got %b expected 1", overrun);
    end
    for (int k = 0; k <= CELLS; k++) begin
      checks++;
      if (busy !== (k < CELLS)) begin
        errors++;
        $display("FAIL overrun_busy_%0d: got %b expected %b", k + 1, busy, (k < CELLS));
      end
      tick();
    end
    x = 10'd320; tick();
    checks++;
    if (color !== 3'b111) begin
      errors++; $display("FAIL overrun_gen_seed_live: got %b expected 111", color);
    end
    x = 10'd312; tick();
    checks++;
    if (color !== 3'b000) begin
      errors++; $display("FAIL overrun_gen_seed_dead: got %b expected 000", color);
    end
    ticks(20);
    checks++;
    if (overrun !== 1'b1) begin
      errors++; $display("FAIL overrun_sticky: got %b expected 1", overrun);
    end
    pulse_reset();
    checks++;
    if (overrun !== 1'b0) begin
      errors++; $display("FAIL overrun_cleared: got %b expected 0", overrun);
    end
  endtask

  task automatic test_reset_abort();
    activevideo = 1'b1;
    y = 10'd1; tick();
    y = 10'd0; tick();
    ticks(30);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    y = 10'd8;
    tick();
    checks++;
    if (busy !== 1'b1) begin
      errors++; $display("FAIL abort_busy: got %b expected 1", busy);
    end
    for (int c = 38; c <= 42; c++) begin
      x = 10'(c * CSIZE + 3);
      tick();
      checks++;
      if (color !== 3'b000) begin
        errors++; $display("FAIL abort_cell_%0d: got %b expected 000", c, color);
      end
    end
    pulse_reset();
  endtask

`ifdef CA_SEED_INPUT_EN
  task automatic test_wrap();
    int xs[4];
    logic [2:0] exp_c[4];
    xs = '{632, 0, 8, 16};
    exp_c = '{3'b111, 3'b111, 3'b111, 3'b000};
    seed = '0;
    seed[0] = 1'b1;
    pulse_reset();
    activevideo = 1'b1;
    y = 10'd1; tick();
    y = 10'd0; tick();
    ticks(90);
    y = 10'd8; tick();
    for (int i = 0; i < 4; i++) begin
      x = 10'(xs[i]);
      tick();
      checks++;
      if (color !== exp_c[i]) begin
        errors++; $display("FAIL wrap_x%0d: got %b expected %b", xs[i], color, exp_c[i]);
      end
    end
    seed = '0;
    seed[CELLS/2] = 1'b1;
    pulse_reset();
  endtask
`endif

  task automatic test_random();
    int cycles;
    int yv;
    cycles = 0;
    yv = 0;
    while (cycles < 4000) begin
      int hold;
      int r;
      r = $urandom_range(0, 99);
      if (r < 55)      yv = (yv + 1) % 48;
      else if (r < 70) yv = 0;
      else             yv = $urandom_range(0, 47);
      y = 10'(yv);
      hold = (r < 30) ? $urandom_range(1, 12) : $urandom_range(1, 120);
      for (int h = 0; h < hold; h++) begin
        x           = 10'($urandom_range(0, 700));
        activevideo = ($urandom_range(0, 4) != 0);
        rst         = ($urandom_range(0, 499) == 0);
        tick();
        cycles++;
        checks++;
        if (color !== m_color) begin
          errors++; $display("FAIL rand_color@%0d: got %b expected %b", cycles, color, m_color);
        end
        checks++;
        if (busy !== (m_busy_left > 0)) begin
          errors++; $display("FAIL rand_busy@%0d: got %b expected %b", cycles, busy, (m_busy_left > 0));
        end
        checks++;
        if (overrun !== m_overrun) begin
          errors++; $display("FAIL rand_overrun@%0d: got %b expected %b", cycles, overrun, m_overrun);
        end
      end
      if (rst) begin
        rst = 1'b0;
        yv = 0;
      end
    end
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    x = '0;
    y = '0;
    activevideo = 1'b0;
`ifdef CA_SEED_INPUT_EN
    seed = '0;
    seed[CELLS/2] = 1'b1;
`endif
    model_reset();
    @(negedge clk);
    test_reset();
    test_rule30_step();
    test_busy_timing();
    test_blanking();
    test_overrun();
    test_reset_abort();
`ifdef CA_SEED_INPUT_EN
    test_wrap();
`endif
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ca_row_renderer.md
CA_ROW_RENDERER -- requirements
Module: ca_row_renderer

Interface
REQ-001 Parameter CELLS, default 80, number of cells per generation (2..256).
REQ-002 Parameter CELL_SHIFT, default 3, cell size in pixels = 2**CELL_SHIFT, square.
REQ-003 Parameter RULE, default 8'd30, Wolfram elementary rule number.
REQ-004 Parameter FG_COLOR, default 3'b111, colour of a live cell; BG_COLOR, default 3'b000, colour of dead cell or background.
REQ-005 clk  input  1  sole clock, all state on rising edge.
REQ-006 rst  input  1  asynchronous, active-high reset.
REQ-007 x  input  10  current pixel column.
REQ-008 y  input  10  current pixel row.
REQ-009 activevideo  input  1  high while the pixel is in the visible area.
REQ-010 color  output  3  registered RGB pixel colour.
REQ-011 busy  output  1  high while the next generation is being computed.
REQ-012 overrun  output  1  sticky; set when a row boundary arrives before computation completes.

Function
REQ-013 State: gen[CELLS-1:0] (displayed generation), shadow[CELLS-1:0] (next generation), y_q (registered y), FSM {IDLE, COMPUTE}, cell index counter idx.
REQ-014 Line event: y != y_q; y_q updates every cycle.
REQ-015 Frame event: line event with y == 0 -> gen loads seed, FSM enters COMPUTE with idx = 0.
REQ-016 Boundary event: line event with y != 0 and y[CELL_SHIFT-1:0] == 0 -> if FSM IDLE: gen <= shadow, enter COMPUTE with idx = 0.
REQ-017 Boundary event during COMPUTE: gen unchanged, overrun <= 1, compute restarts at idx = 0 from current gen.
REQ-018 Frame event takes priority over COMPUTE in progress: seed loads, compute restarts, overrun unaffected.
REQ-019 COMPUTE: one cell per cycle, shadow[idx] <= RULE[{gen[idx-1], gen[idx], gen[idx+1]}] with neighbour indices modulo CELLS (left of 0 is CELLS-1, right of CELLS-1 is 0).
REQ-020 busy high for exactly CELLS cycles beginning the cycle after the triggering event; FSM returns to IDLE after idx = CELLS-1.
REQ-021 Cell column c = x >> CELL_SHIFT; cell 0 leftmost, mapped to gen[0].
REQ-022 color <= FG_COLOR when activevideo && c < CELLS && gen[c]; else BG_COLOR; latency one cycle from x/y/activevideo.
REQ-023 Pixel lookup uses gen value before any same-cycle update.

Reset
REQ-024 While rst high: color = BG_COLOR, busy = 0, overrun = 0, FSM IDLE, idx = 0, y_q = 0, gen = seed, shadow = 0.
REQ-025 rst asserted mid-COMPUTE aborts computation immediately; no partial shadow is committed.

Configuration
REQ-026 Macro CA_SEED_INPUT_EN: when defined, input port seed [CELLS-1:0] exists and is sampled as seed on frame event and reset.
REQ-027 Without CA_SEED_INPUT_EN: no seed port; seed is a single live cell at index CELLS/2 (bit 40 by default).

Verification
REQ-028 Reset (defaults, macro off): rst=1 -> color=000, busy=0, overrun=0; x=320,y=0,activevideo=1 after release -> color=111 next cycle; x=319 -> 000.
REQ-029 Rule 30 step: frame event then y 7->8 after >80 idle cycles -> live cells 39,40,41; x=312 and x=335 -> 111, x=311 and x=336 -> 000.
REQ-030 Busy timing: frame event at cycle E -> busy=1 cycles E+1..E+80, 0 at E+81.
REQ-031 Wrap-around, macro on: seed = bit 0 only, frame event, y 0->8 -> live cells 79,0,1; x=632 -> 111.
REQ-032 Blanking/range: gen all ones, activevideo=0 -> 000; activevideo=1, x=640 (c=80) -> 000.
REQ-033 Overrun: frame event, y 0->8 within 10 cycles -> overrun=1 sticky, gen still equals seed, busy restarts for 80 cycles; rst clears overrun.
